// File: rtl/vend_pkg.sv
// Shared state encoding, coin values and saturating credit add for the dispense scheduler.
package vend_pkg;

    typedef enum logic [2:0] {IDLE, GRANT, DISP, CHANGE, CLEAR} state_t;

    localparam int COIN5_U  = 1;
    localparam int COIN10_U = 2;
    localparam int SAT_W    = 8;

    // Returns {ok, sum}; when the sum would pass max_v, ok=0 and the credit comes back unchanged.
    function automatic logic [SAT_W:0] sat_add(
        input logic [SAT_W-1:0] credit,
        input logic [SAT_W-1:0] value,
        input logic [SAT_W-1:0] max_v
    );
        logic [SAT_W:0] sum;
        sum = {1'b0, credit} + {1'b0, value};
        if (sum > {1'b0, max_v}) begin
            return {1'b0, credit};
        end
        return {1'b1, sum[SAT_W-1:0]};
    endfunction

endpackage

// File: rtl/vend_credit_acc.sv
// Per-panel coin decode, refuse pulse and credit register.
// With VEND_TIMEOUT_REFUND_EN defined it also keeps an idle counter that raises timeout_req.
module vend_credit_acc
    import vend_pkg::*;
#(
    parameter int PRICE_U  = 3,
    parameter int CREDIT_W = 3
`ifdef VEND_TIMEOUT_REFUND_EN
    ,
    parameter int TIMEOUT  = 255
`endif
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in5,
    input  logic                in10,
    input  logic                busy,
    input  logic                clr,
    output logic [CREDIT_W-1:0] credit,
    output logic                refuse,
    output logic                eligible,
    output logic                timeout_req
);

    localparam logic [CREDIT_W-1:0] PRICE_C  = CREDIT_W'(PRICE_U);
    localparam int                  CRED_MAX = (1 << CREDIT_W) - 1;

    logic [CREDIT_W-1:0] r_credit;
    logic                r_refuse;
    logic [1:0]          w_val;
    logic                w_coin;
    logic                w_accept;
    logic [SAT_W:0]      w_add;

    // A simultaneous in10/in5 pair keeps the 10 and bounces the 5.
    assign w_val    = in10 ? 2'(COIN10_U) : (in5 ? 2'(COIN5_U) : 2'd0);
    assign w_coin   = in5 | in10;
    assign w_add    = sat_add(SAT_W'(r_credit), SAT_W'(w_val), SAT_W'(CRED_MAX));
    assign w_accept = w_coin & ~busy & (r_credit < PRICE_C) & w_add[SAT_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_credit <= '0;
            r_refuse <= 1'b0;
        end else begin
            r_refuse <= (in5 & in10) | (w_coin & ~w_accept);
            if (clr) begin
                r_credit <= '0;
            end else if (w_accept) begin
                r_credit <= CREDIT_W'(w_add[SAT_W-1:0]);
            end
        end
    end

`ifdef VEND_TIMEOUT_REFUND_EN
    localparam int              TO_W = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_C = TO_W'(TIMEOUT);

    logic [TO_W-1:0] r_idle_cnt;

    always_ff @(posedge clk) begin
        if (reset || w_accept || clr || (r_credit == '0)) begin
            r_idle_cnt <= '0;
        end else if (!busy && (r_idle_cnt != TO_C)) begin
            r_idle_cnt <= r_idle_cnt + TO_W'(1);
        end
    end

    assign timeout_req = (r_idle_cnt == TO_C) && (r_credit != '0) && (r_credit < PRICE_C);
`else
    assign timeout_req = 1'b0;
`endif

    assign credit   = r_credit;
    assign refuse   = r_refuse;
    assign eligible = (r_credit >= PRICE_C);

endmodule

// File: rtl/vend_dispense_sched.sv
// Two coin panels sharing one dispenser and change hopper via a round-robin service FSM.
// Define VEND_TIMEOUT_REFUND_EN to refund stale partial credit after TIMEOUT idle cycles.
module vend_dispense_sched
    import vend_pkg::*;
#(
    parameter int PRICE_U  = 3,
    parameter int CREDIT_W = 3,
    parameter int TIMEOUT  = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       p0_in5,
    input  logic       p0_in10,
    input  logic       p1_in5,
    input  logic       p1_in10,
    input  logic       disp_ack,
    output logic       disp_req,
    output logic       disp_port,
    output logic       hop_pulse,
    output logic [1:0] refuse,
    output logic [1:0] done
);

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE_U);

    state_t                    r_state;
    state_t                    w_next;
    logic                      r_sel;
    logic                      r_refund;
    logic                      r_rr_last;
    logic [CREDIT_W-1:0]       r_change;
    logic [1:0]                r_done;
    logic [1:0]                w_in5;
    logic [1:0]                w_in10;
    logic [1:0]                w_busy;
    logic [1:0]                w_clr;
    logic [1:0]                w_refuse;
    logic [1:0]                w_elig;
    logic [1:0]                w_treq;
    logic [1:0]                w_req;
    logic [1:0][CREDIT_W-1:0]  w_credit;
    logic                      w_pick;

    assign w_in5  = {p1_in5, p0_in5};
    assign w_in10 = {p1_in10, p0_in10};

    for (genvar i = 0; i < 2; i++) begin : g_panel
        assign w_busy[i] = (r_state != IDLE) && (r_sel == 1'(i));
        assign w_clr[i]  = (r_state == CLEAR) && (r_sel == 1'(i));

        vend_credit_acc #(
            .PRICE_U  (PRICE_U),
            .CREDIT_W (CREDIT_W)
`ifdef VEND_TIMEOUT_REFUND_EN
            ,
            .TIMEOUT  (TIMEOUT)
`endif
        ) u_acc (
            .clk         (clk),
            .reset       (reset),
            .in5         (w_in5[i]),
            .in10        (w_in10[i]),
            .busy        (w_busy[i]),
            .clr         (w_clr[i]),
            .credit      (w_credit[i]),
            .refuse      (w_refuse[i]),
            .eligible    (w_elig[i]),
            .timeout_req (w_treq[i])
        );
    end

    // Sales win over refunds; a tie inside the winning class goes to the panel not served last.
    assign w_req  = (|w_elig) ? w_elig : w_treq;
    assign w_pick = (w_req == 2'b11) ? ~r_rr_last : w_req[1];

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (|w_req) w_next = GRANT;
            GRANT:   w_next = r_refund ? CHANGE : DISP;
            DISP:    if (disp_ack) w_next = (r_change == '0) ? CLEAR : CHANGE;
            CHANGE:  if (r_change == CREDIT_W'(1)) w_next = CLEAR;
            CLEAR:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_sel     <= 1'b0;
            r_refund  <= 1'b0;
            r_rr_last <= 1'b1;
            r_change  <= '0;
            r_done    <= 2'b00;
        end else begin
            r_state <= w_next;
            r_done  <= (r_state == CLEAR) ? (r_sel ? 2'b10 : 2'b01) : 2'b00;
            if ((r_state == IDLE) && (|w_req)) begin
                r_sel     <= w_pick;
                r_rr_last <= w_pick;
                r_refund  <= ~(|w_elig);
            end
            if (r_state == GRANT) begin
                r_change <= r_refund ? w_credit[r_sel] : (w_credit[r_sel] - PRICE_C);
            end else if (r_state == CHANGE) begin
                r_change <= r_change - CREDIT_W'(1);
            end
        end
    end

    assign disp_req  = (r_state == DISP);
    assign disp_port = disp_req & r_sel;
    assign hop_pulse = (r_state == CHANGE);
    assign refuse    = w_refuse;
    assign done      = r_done;

endmodule

// File: tb/tb_vend_dispense_sched.sv
// Directed bench for vend_dispense_sched: sale, change, round-robin, refusal and reset abort.
module tb_vend_dispense_sched;
    import vend_pkg::*;

`ifdef VEND_TIMEOUT_REFUND_EN
    localparam int TB_TO = 8;
`else
    localparam int TB_TO = 255;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       p0_in5 = 1'b0, p0_in10 = 1'b0, p1_in5 = 1'b0, p1_in10 = 1'b0;
    logic       disp_ack = 1'b0;
    logic       disp_req, disp_port, hop_pulse;
    logic [1:0] refuse, done;

    int n_tests = 0;
    int n_fail  = 0;

    vend_dispense_sched #(.PRICE_U(3), .CREDIT_W(3), .TIMEOUT(TB_TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .p0_in5    (p0_in5),
        .p0_in10   (p0_in10),
        .p1_in5    (p1_in5),
        .p1_in10   (p1_in10),
        .disp_ack  (disp_ack),
        .disp_req  (disp_req),
        .disp_port (disp_port),
        .hop_pulse (hop_pulse),
        .refuse    (refuse),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        p0_in5 = 0; p0_in10 = 0; p1_in5 = 0; p1_in10 = 0; disp_ack = 0;
        reset = 1;
        step();
        reset = 0;
    endtask

    // Waits (bounded) for a dispense request, acks it, then collects hop pulses until done.
    task automatic serve_obs(output logic port, output int hops, output logic [1:0] dn, output bit tmo);
        port = 0; hops = 0; dn = 2'b00; tmo = 1;
        for (int k = 0; k < 10 && !disp_req; k++) step();
        if (!disp_req) return;
        port = disp_port;
        disp_ack = 1; step(); disp_ack = 0;
        for (int j = 0; j < 20; j++) begin
            if (done != 2'b00) begin
                dn = done; tmo = 0;
                break;
            end
            if (hop_pulse) hops++;
            step();
        end
    endtask

    task automatic test_reset();
        p0_in10 = 1; p1_in10 = 1; step();
        do_reset();
        n_tests++;
        if ({disp_req, disp_port, hop_pulse, refuse, done} !== 7'b0) begin
            n_fail++; $display("FAIL reset_outputs: got %b want 0", {disp_req, disp_port, hop_pulse, refuse, done});
        end
        n_tests++;
        if ({dut.w_credit[1], dut.w_credit[0]} !== 6'd0) begin
            n_fail++; $display("FAIL reset_credits: got %0d/%0d want 0/0", dut.w_credit[0], dut.w_credit[1]);
        end
        n_tests++;
        if (dut.r_state !== IDLE) begin
            n_fail++; $display("FAIL reset_state: got %0d want %0d", dut.r_state, IDLE);
        end
        disp_ack = 1; step(); disp_ack = 0; step();
        n_tests++;
        if ({disp_req, hop_pulse, done} !== 4'b0) begin
            n_fail++; $display("FAIL idle_ack_ignored: got %b want 0", {disp_req, hop_pulse, done});
        end
    endtask

    task automatic test_exact_price();
        do_reset();
        p0_in10 = 1; step(); p0_in10 = 0;
        p0_in5 = 1; step(); p0_in5 = 0;
        step();
        n_tests++;
        if (disp_req !== 1'b0) begin
            n_fail++; $display("FAIL t1_grant_cycle_req: got %b want 0", disp_req);
        end
        step();
        n_tests++;
        if ({disp_req, disp_port} !== 2'b10) begin
            n_fail++; $display("FAIL t1_disp_req_port: got %b want 10", {disp_req, disp_port});
        end
        disp_ack = 1; step(); disp_ack = 0;
        n_tests++;
        if ({disp_req, hop_pulse, done} !== 4'b0) begin
            n_fail++; $display("FAIL t1_clear_cycle: got %b want 0000", {disp_req, hop_pulse, done});
        end
        step();
        n_tests++;
        if (done !== 2'b01) begin
            n_fail++; $display("FAIL t1_done: got %b want 01", done);
        end
        n_tests++;
        if (dut.w_credit[0] !== 3'd0) begin
            n_fail++; $display("FAIL t1_credit0_cleared: got %0d want 0", dut.w_credit[0]);
        end
        step();
        n_tests++;
        if (done !== 2'b00) begin
            n_fail++; $display("FAIL t1_done_one_cycle: got %b want 00", done);
        end
    endtask

    task automatic test_change();
        logic port; int hops; logic [1:0] dn; bit tmo;
        do_reset();
        p1_in10 = 1; step(); step(); p1_in10 = 0;
        disp_ack = 1; step(); step(); disp_ack = 0;
        step();
        n_tests++;
        if ({disp_req, disp_port} !== 2'b11) begin
            n_fail++; $display("FAIL t2_early_ack_ignored: got %b want 11", {disp_req, disp_port});
        end
        serve_obs(port, hops, dn, tmo);
        n_tests++;
        if (tmo || port !== 1'b1 || hops != 1 || dn !== 2'b10) begin
            n_fail++; $display("FAIL t2_change_service: got tmo=%0d port=%b hops=%0d done=%b want tmo=0 port=1 hops=1 done=10", tmo, port, hops, dn);
        end
    endtask

    task automatic test_back_to_back();
        logic port; int hops; logic [1:0] dn; bit tmo;
        do_reset();
        p0_in10 = 1; p1_in10 = 1; step(); p0_in10 = 0; p1_in10 = 0;
        p0_in5 = 1; p1_in5 = 1; step(); p0_in5 = 0; p1_in5 = 0;
        serve_obs(port, hops, dn, tmo);
        n_tests++;
        if (tmo || port !== 1'b0 || hops != 0 || dn !== 2'b01) begin
            n_fail++; $display("FAIL t3_first_p0: got tmo=%0d port=%b hops=%0d done=%b want tmo=0 port=0 hops=0 done=01", tmo, port, hops, dn);
        end
        serve_obs(port, hops, dn, tmo);
        n_tests++;
        if (tmo || port !== 1'b1 || hops != 0 || dn !== 2'b10) begin
            n_fail++; $display("FAIL t3_second_p1: got tmo=%0d port=%b hops=%0d done=%b want tmo=0 port=1 hops=0 done=10", tmo, port, hops, dn);
        end
    endtask

    task automatic test_refuse();
        logic port; int hops; logic [1:0] dn; bit tmo;
        do_reset();
        p0_in5 = 1; p0_in10 = 1; step(); p0_in5 = 0; p0_in10 = 0;
        n_tests++;
        if (refuse !== 2'b01 || dut.w_credit[0] !== 3'd2) begin
            n_fail++; $display("FAIL t4_pair_coin: got refuse=%b credit0=%0d want 01/2", refuse, dut.w_credit[0]);
        end
        step();
        n_tests++;
        if (refuse !== 2'b00) begin
            n_fail++; $display("FAIL t4_refuse_one_cycle: got %b want 00", refuse);
        end
        p0_in5 = 1; step();
        step(); p0_in5 = 0;
        n_tests++;
        if (refuse !== 2'b01 || dut.w_credit[0] !== 3'd3) begin
            n_fail++; $display("FAIL t4_full_credit_refuse: got refuse=%b credit0=%0d want 01/3", refuse, dut.w_credit[0]);
        end
        p1_in10 = 1; step(); p1_in10 = 0;
        n_tests++;
        if (disp_req !== 1'b1 || refuse !== 2'b00 || dut.w_credit[1] !== 3'd2) begin
            n_fail++; $display("FAIL t4_p1_accept: got req=%b refuse=%b credit1=%0d want 1/00/2", disp_req, refuse, dut.w_credit[1]);
        end
        p0_in10 = 1; step(); p0_in10 = 0;
        n_tests++;
        if (refuse !== 2'b01) begin
            n_fail++; $display("FAIL t4_busy_refuse: got %b want 01", refuse);
        end
        serve_obs(port, hops, dn, tmo);
        n_tests++;
        if (tmo || port !== 1'b0 || hops != 0 || dn !== 2'b01) begin
            n_fail++; $display("FAIL t4_service: got tmo=%0d port=%b hops=%0d done=%b want tmo=0 port=0 hops=0 done=01", tmo, port, hops, dn);
        end
        n_tests++;
        if (dut.w_credit[0] !== 3'd0 || dut.w_credit[1] !== 3'd2) begin
            n_fail++; $display("FAIL t4_credits_after: got %0d/%0d want 0/2", dut.w_credit[0], dut.w_credit[1]);
        end
    endtask

    task automatic test_reset_mid_service();
        int seen;
        do_reset();
        p1_in10 = 1; step(); p1_in10 = 0;
        p0_in10 = 1; step(); step(); p0_in10 = 0;
        step(); step();
        n_tests++;
        if (disp_req !== 1'b1) begin
            n_fail++; $display("FAIL t5_disp_reached: got %b want 1", disp_req);
        end
        disp_ack = 1; step(); disp_ack = 0;
        n_tests++;
        if (hop_pulse !== 1'b1) begin
            n_fail++; $display("FAIL t5_change_entered: got %b want 1", hop_pulse);
        end
        reset = 1; step(); reset = 0;
        n_tests++;
        if ({hop_pulse, disp_req} !== 2'b00 || dut.r_state !== IDLE) begin
            n_fail++; $display("FAIL t5_abort: got hop=%b req=%b state=%0d want 0/0/%0d", hop_pulse, disp_req, dut.r_state, IDLE);
        end
        n_tests++;
        if ({dut.w_credit[1], dut.w_credit[0]} !== 6'd0) begin
            n_fail++; $display("FAIL t5_credits_lost: got %0d/%0d want 0/0", dut.w_credit[0], dut.w_credit[1]);
        end
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (disp_req || hop_pulse || done != 2'b00) seen++;
        end
        n_tests++;
        if (seen != 0) begin
            n_fail++; $display("FAIL t5_quiet_after: got %0d active cycles want 0", seen);
        end
    endtask

`ifdef VEND_TIMEOUT_REFUND_EN
    task automatic test_timeout_refund();
        int hops; bit saw_disp; logic [1:0] dn;
        do_reset();
        p0_in5 = 1; step(); p0_in5 = 0;
        hops = 0; saw_disp = 0; dn = 2'b00;
        for (int k = 0; k < 40; k++) begin
            if (disp_req) saw_disp = 1;
            if (hop_pulse) hops++;
            if (done != 2'b00) begin
                dn = done;
                break;
            end
            step();
        end
        n_tests++;
        if (saw_disp || hops != 1 || dn !== 2'b01) begin
            n_fail++; $display("FAIL t6_refund: got disp=%0d hops=%0d done=%b want 0/1/01", saw_disp, hops, dn);
        end
    endtask
`else
    task automatic test_partial_hold();
        int seen;
        do_reset();
        p0_in5 = 1; step(); p0_in5 = 0;
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (disp_req || hop_pulse || done != 2'b00) seen++;
        end
        n_tests++;
        if (seen != 0 || dut.w_credit[0] !== 3'd1) begin
            n_fail++; $display("FAIL t6_partial_hold: got active=%0d credit0=%0d want 0/1", seen, dut.w_credit[0]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_exact_price();
        test_change();
        test_back_to_back();
        test_refuse();
        test_reset_mid_service();
`ifdef VEND_TIMEOUT_REFUND_EN
        test_timeout_refund();
`else
        test_partial_hold();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
